// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam int PS2_DATA_BITS = 8;

    // Position of the next byte within a 3-byte movement packet
    localparam logic [1:0] PKT_STATUS = 2'd0;
    localparam logic [1:0] PKT_X      = 2'd1;
    localparam logic [1:0] PKT_Y      = 2'd2;

    // Bit positions inside the status byte
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

endpackage

// File: rtl/ps2_line_filter.sv
// Brings the asynchronous PS/2 lines into the system clock domain.
// The clock line is debounced and turned into a one-cycle falling-edge strobe;
// the data line is only synchronised, since it is sampled mid-bit.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock_100Mhz,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic          clk_s1_q, clk_s2_q;
    logic          data_s1_q, data_s2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_q, fall_d;

    // Two-flop synchronisers; lines idle high so reset to 1
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN
    // consecutive differing samples; any agreeing sample restarts the run
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = flt_cnt_q;
        if (clk_s2_q == filt_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_d    = clk_s2_q;
            flt_cnt_d = '0;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
    end

    // Filter state and registered falling-edge strobe
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
            fall_q    <= fall_d;
        end
    end

    assign clk_fall  = fall_q;
    assign data_sync = data_s2_q;

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: deframes 11-bit frames, checks start/parity/stop,
// assembles 3-byte movement packets and publishes sign-extended deltas.
module ps2_mouse_packet_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       pkt_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [2:0] buttons,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       frame_err,
    output logic       sync_err
);

    localparam int               TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_HIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic clk_fall, data_s;

    ps2_line_filter #(.FILTER_LEN(CLK_FILTER_LEN)) u_filt (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .clk_fall     (clk_fall),
        .data_sync    (data_s)
    );

    frame_state_t    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_stb_q, byte_stb_d;
    logic            frame_err_q, frame_err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            frame_bad, to_hit;

    logic [1:0]      pkt_idx_q, pkt_idx_d;
    logic [7:0]      status_q, status_d;
    logic [7:0]      x_q, x_d;
    logic [8:0]      dx_q, dx_d, dy_q, dy_d;
    logic [2:0]      buttons_q, buttons_d;
    logic            x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            sync_err_q, sync_err_d;

    // Frame deframer and inactivity timeout; one step per filtered falling edge
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        byte_d      = byte_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        frame_bad   = 1'b0;
        to_hit      = 1'b0;
        to_cnt_d    = to_cnt_q;
        if (clk_fall) begin
            // An edge always wins over a coincident timeout
            to_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    if ((^shift_q ^ par_q) && data_s) begin
                        byte_d     = shift_q;
                        byte_stb_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        frame_bad   = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_HIT) begin
                to_hit = 1'b1;
                if (state_q != IDLE) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        end
    end

    // Packet assembly; outputs are registered one cycle after the Y byte strobe
    always_comb begin
        pkt_idx_d   = pkt_idx_q;
        status_d    = status_q;
        x_d         = x_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        buttons_d   = buttons_q;
        x_ovf_d     = x_ovf_q;
        y_ovf_d     = y_ovf_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        if (frame_bad || to_hit) begin
            pkt_idx_d = PKT_STATUS;
        end else if (byte_stb_q) begin
            unique case (pkt_idx_q)
                PKT_STATUS: begin
                    if (byte_q[SYNC]) begin
                        status_d  = byte_q;
                        pkt_idx_d = PKT_X;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                PKT_X: begin
                    x_d       = byte_q;
                    pkt_idx_d = PKT_Y;
                end
                PKT_Y: begin
                    dx_d        = {status_q[XSIGN], x_q};
                    dy_d        = {status_q[YSIGN], byte_q};
                    buttons_d   = status_q[2:0];
                    x_ovf_d     = status_q[XOVF];
                    y_ovf_d     = status_q[YOVF];
                    pkt_valid_d = 1'b1;
                    pkt_idx_d   = PKT_STATUS;
                end
                default: pkt_idx_d = PKT_STATUS;
            endcase
        end
    end

    // State registers for both the deframer and the packet assembler
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            byte_q      <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            to_cnt_q    <= '0;
            pkt_idx_q   <= PKT_STATUS;
            status_q    <= '0;
            x_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            buttons_q   <= '0;
            x_ovf_q     <= 1'b0;
            y_ovf_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            byte_q      <= byte_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
            to_cnt_q    <= to_cnt_d;
            pkt_idx_q   <= pkt_idx_d;
            status_q    <= status_d;
            x_q         <= x_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            buttons_q   <= buttons_d;
            x_ovf_q     <= x_ovf_d;
            y_ovf_q     <= y_ovf_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign buttons   = buttons_q;
    assign x_ovf     = x_ovf_q;
    assign y_ovf     = y_ovf_q;
    assign frame_err = frame_err_q;
    assign sync_err  = sync_err_q;

endmodule

// File: doc/ps2_mouse_packet_rx.md
Name: ps2_mouse_packet_rx

Overview:
Receive-only PS/2 mouse front end in the clock_100Mhz domain, directly upstream of the position tracker / 7-seg display stage.
- Synchronises and glitch-filters the mouse clock and data lines.
- Deframes 11-bit PS/2 frames and checks start, odd parity and stop bits.
- Assembles 3-byte movement packets and emits one-cycle-valid, sign-extended dx/dy plus button state.
- Replaces direct use of the raw PS/2 clock as a clock.

Parameters:
CLK_FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required before the filtered clock changes
TIMEOUT_CYCLES, 200000, idle cycles (2 ms) without a filtered falling edge before a partial frame/packet is abandoned

Ports:
clock_100Mhz  in   1  system clock, 100 MHz
reset         in   1  asynchronous, active-high; clock clock_100Mhz
ps2_clk       in   1  raw PS/2 clock from mouse (asynchronous)
ps2_data      in   1  raw PS/2 data from mouse (asynchronous)
pkt_valid     out  1  one-cycle pulse: new packet on dx/dy/buttons/ovf
dx            out  9  signed X delta {status[4], byte1}
dy            out  9  signed Y delta {status[5], byte2}
buttons       out  3  {middle, right, left} = status[2:0]
x_ovf         out  1  status[6]
y_ovf         out  1  status[7]
frame_err     out  1  one-cycle pulse: start/parity/stop error or mid-frame timeout
sync_err      out  1  one-cycle pulse: byte 0 received with bit3 = 0

Behaviour:
- Reset: all outputs 0; FSM to IDLE; packet index 0; filter state = 1 (line idle high); timeout counter 0.
- Input conditioning:
  - 2-FF synchroniser on both lines.
  - Filtered clk changes only after CLK_FILTER_LEN consecutive equal synchronised samples.
  - Falling edge = filtered clk 1->0, registered; sample synchronised data in the edge cycle.
- Frame FSM, advancing one step per falling edge:
  - IDLE: data 0 -> DATA, bit counter 0. Data 1 -> stay IDLE, no error.
  - DATA: shift LSB-first; after 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: good frame iff XOR(data, parity) = 1 and stop bit = 1. Good -> byte strobe. Bad -> frame_err, discard byte, packet index 0. Either way -> IDLE.
- Timeout:
  - Counter clears on every falling edge and counts otherwise; saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: if FSM not IDLE -> frame_err pulse, FSM IDLE. If packet index != 0 -> index 0, no pulse for this alone.
  - A falling edge in the same cycle wins: counter clears, no timeout.
- Packet assembly on byte strobe:
  - Index 0: bit3 = 1 -> latch status, index 1. Bit3 = 0 -> sync_err pulse, stay index 0.
  - Index 1: latch X byte, index 2.
  - Index 2: latch Y byte, index 0; in the next cycle update dx/dy/buttons/x_ovf/y_ovf and pulse pkt_valid for exactly one cycle.
- Latency: pkt_valid is high exactly 2 cycles after the stop-bit edge-detect cycle of byte 2.
- Outputs hold their values between packets.
- Output pulses never coexist with pkt_valid from the same frame.
- Reset mid-frame or mid-packet: everything discarded; no pulses until a new start bit.
- Receive only: ps2_clk/ps2_data are never driven, and host inhibit is out of scope.

Decomposition:
- Package ps2_pkg:
  - frame state enum {IDLE, DATA, PARITY, STOP}
  - PS2_DATA_BITS = 8
  - packet index constants PKT_STATUS = 0, PKT_X = 1, PKT_Y = 2
  - status bit positions: SYNC = 3, XSIGN = 4, YSIGN = 5, XOVF = 6, YOVF = 7
- Sub-module ps2_line_filter: synchroniser, glitch filter and registered falling-edge detect for ps2_clk; 2-FF synchronised ps2_data passthrough. Instantiated once.

Test Plan:
Bench settings: CLK_FILTER_LEN = 4, TIMEOUT_CYCLES = 1000, PS/2 clock period 200 cycles.
1. Bytes 0x28, 0x05, 0xFB, valid odd parity -> one pkt_valid pulse, 2 cycles after the last stop edge; dx = 9'h005, dy = 9'h1FB (-5), buttons = 0, ovf = 0.
2. Bytes 0x19, 0xF0, 0x00 -> dx = 9'h1F0 (-16), dy = 0, buttons = 3'b001; outputs hold afterwards.
3. Byte 1 sent with wrong parity -> frame_err pulse, no pkt_valid. Then full packet 0x08, 0x01, 0x02 -> pkt_valid with dx = 1, dy = 2.
4. First byte 0x05 (bit3 = 0) -> sync_err pulse. Then 0x08, 0x03, 0x04 -> pkt_valid with dx = 3, dy = 4.
5. 2-cycle low glitch on ps2_clk between bits of a frame -> no extra bit; packet 0x08, 0x7F, 0x80 decodes dx = 9'h07F, dy = 9'h080.
6. Frame abandoned after 5 bits, line idle 1200 cycles -> exactly one frame_err. Then good packet decodes. Separately, reset asserted mid-byte 1 -> all outputs 0 and no pulses.
